// File: rtl/mem_stage_ctrl_if.sv
// Data-memory handshake between the M-stage controller (master) and the data memory (slave).
interface mem_stage_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_ctrl.sv
// D->M pipeline register and memory-stage controller: data-memory handshake, D stall, timeout abort,
// M-stage writeback/forwarding select. Define MEM_STAGE_PERF_EN to add retired_cnt/stall_cnt counters.
module mem_stage_ctrl #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_D,
    input  logic [XLEN-1:0] pc_D,
    input  logic [XLEN-1:0] alu_res_D,
    input  logic [XLEN-1:0] st_data_D,
    input  logic [4:0]      rd_D,
    input  logic            rf_en_D,
    input  logic            mem_rd_D,
    input  logic            mem_wr_D,
    input  logic [1:0]      wb_sel_D,
    output logic            stall_D,
    output logic            valid_M,
    output logic [4:0]      rd_M,
    output logic            rf_en_M,
    output logic [XLEN-1:0] wdata_M,
    output logic            mem_err,
`ifdef MEM_STAGE_PERF_EN
    output logic [31:0]     retired_cnt,
    output logic [31:0]     stall_cnt,
`endif
    mem_stage_ctrl_if.master dmem
);

    localparam int             CW       = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] st_data;
        logic [4:0]      rd;
        logic            rf_en;
        logic            mem_rd;
        logic            mem_wr;
        logic [1:0]      wb_sel;
    } m_regs_t;

    m_regs_t       m_q, m_d;
    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic          req;
    logic          abort;
    logic [CW-1:0] cnt_now;

    // Ack/abort release the stall, so the next instruction is captured on that same edge and a
    // finished access never lingers in M: the request needs no separate "done" qualifier.
    assign req     = m_q.valid & (m_q.mem_rd | m_q.mem_wr);
    assign cnt_now = (state_q == ST_WAIT) ? wait_cnt_q : '0;
    assign abort   = req & ~dmem.ack & (cnt_now == CNT_LAST);
    assign stall_D = req & ~dmem.ack & ~abort;
    assign mem_err = abort;

    assign dmem.req   = req;
    assign dmem.we    = m_q.valid & m_q.mem_wr;
    assign dmem.addr  = m_q.alu_res;
    assign dmem.wdata = m_q.st_data;

    assign valid_M = m_q.valid;
    assign rd_M    = m_q.rd;
    // x0 is never forwarded, and nothing is forwarded while the access is still pending or aborted.
    assign rf_en_M = m_q.valid & m_q.rf_en & (m_q.rd != 5'd0) & ~stall_D & ~abort;

    always_comb begin
        unique case (m_q.wb_sel)
            2'd1:    wdata_M = dmem.rdata;
            2'd2:    wdata_M = m_q.pc + XLEN'(4);
            default: wdata_M = m_q.alu_res;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the block infers a latch.
        m_d        = m_q;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (!stall_D) begin
            m_d.valid   = valid_D;
            m_d.pc      = pc_D;
            m_d.alu_res = alu_res_D;
            m_d.st_data = st_data_D;
            m_d.rd      = rd_D;
            m_d.rf_en   = rf_en_D;
            m_d.mem_rd  = mem_rd_D;
            m_d.mem_wr  = mem_wr_D;
            m_d.wb_sel  = wb_sel_D;
        end

        unique case (state_q)
            ST_RUN: begin
                if (req && !dmem.ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = CW'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (dmem.ack || abort) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            m_q        <= '0;
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            m_q        <= m_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q + 32'(m_q.valid & ~stall_D);
        stall_cnt_d   = stall_cnt_q + 32'(stall_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule
